// File: rtl/gate_test_pkg.sv
// Purpose: shared types and constants for the two-input gate test sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gate_test_pkg;

  // One vector per {a,b} combination of a two-input gate.
  localparam int NUM_VECTORS = 4;
  localparam int IDX_W       = $clog2(NUM_VECTORS);

  // Truth tables, bit k = expected y for input vector k = {a,b}.
  localparam logic [NUM_VECTORS-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VECTORS-1:0] TT_NAND = 4'b0111;
  localparam logic [NUM_VECTORS-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VECTORS-1:0] TT_XOR  = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bits set where the captured response disagrees with the reference table.
  function automatic logic [NUM_VECTORS-1:0] mismatch_mask(
    input logic [NUM_VECTORS-1:0] observed,
    input logic [NUM_VECTORS-1:0] reference
  );
    return observed ^ reference;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Purpose: down-counter timing how long each input vector is held before sampling.
// Latency: expired is high in the last of SETTLE_CYCLES ticked cycles after load.
// Backpressure: none; counter saturates at 0 and never wraps.
// Ports: clk/rst_n clock and async reset; clear forces 0 (highest priority);
//        load presets SETTLE_CYCLES; tick decrements; expired flags the final count.
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_ZERO;
    end else if (clear) begin
      cnt_q <= CNT_ZERO;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (tick && (cnt_q != CNT_ZERO)) begin
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  // Loaded with N, so the Nth settle cycle is the one holding a count of 1.
  assign expired = (cnt_q == CNT_ONE);

endmodule

// File: rtl/gate_test_sequencer.sv
// Purpose: walks a two-input gate through all four {a,b} vectors and checks y against EXPECTED.
// Latency: done pulses 4*(SETTLE_CYCLES+1)+1 cycles after start is accepted.
// Backpressure: none; start is ignored unless IDLE, abort cancels a run on the next edge.
// Ports: clk, rst_n (async active-low); start, abort controls; gate_a/gate_b drive the
//        gate, gate_y is its response; busy, done, result, pass, fail_mask report status.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int unsigned                SETTLE_CYCLES = 2,
  parameter logic [NUM_VECTORS-1:0]     EXPECTED      = TT_AND
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   gate_a,
  output logic                   gate_b,
  input  logic                   gate_y,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_VECTORS-1:0] result,
  output logic                   pass,
  output logic [NUM_VECTORS-1:0] fail_mask
);

  generate
    if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("gate_test_sequencer: SETTLE_CYCLES must be within 1..255");
    end
  endgenerate

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VECTORS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_VECTORS-1:0] result_q, result_d;
  logic                   pass_q, pass_d;
  logic [NUM_VECTORS-1:0] fail_mask_q, fail_mask_d;

  logic tmr_clear;
  logic tmr_load;
  logic tmr_tick;
  logic tmr_expired;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .load   (tmr_load),
    .tick   (tmr_tick),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      result_q    <= '0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    result_d    = result_q;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    tmr_clear   = 1'b0;
    tmr_load    = 1'b0;
    tmr_tick    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d     = ST_SETTLE;
          idx_d       = '0;
          result_d    = '0;
          pass_d      = 1'b0;
          fail_mask_d = '0;
          tmr_load    = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d     = ST_IDLE;
          idx_d       = '0;
          result_d    = '0;
          pass_d      = 1'b0;
          fail_mask_d = '0;
          tmr_clear   = 1'b1;
        end else begin
          tmr_tick = 1'b1;
          if (tmr_expired) begin
            state_d = ST_SAMPLE;
          end
        end
      end

      ST_SAMPLE: begin
        // Abort wins over the capture: the whole result is discarded.
        if (abort) begin
          state_d     = ST_IDLE;
          idx_d       = '0;
          result_d    = '0;
          pass_d      = 1'b0;
          fail_mask_d = '0;
          tmr_clear   = 1'b1;
        end else begin
          result_d[idx_q] = gate_y;
          if (idx_q == IDX_LAST) begin
            // Verdict is formed from the just-completed result so it is valid in DONE.
            state_d     = ST_DONE;
            idx_d       = '0;
            pass_d      = (result_d == EXPECTED);
            fail_mask_d = mismatch_mask(result_d, EXPECTED);
          end else begin
            state_d  = ST_SETTLE;
            idx_d    = idx_q + IDX_ONE;
            tmr_load = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs decode from registered state so reset clears them immediately.
  logic running;
  assign running   = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign gate_a    = running & idx_q[1];
  assign gate_b    = running & idx_q[0];
  assign busy      = running;
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Purpose: directed self-checking bench for gate_test_sequencer with behavioural gate models.
// Latency: checks cycle-exact vector drive, done timing, abort and async reset.
// Backpressure: n/a.
module tb_gate_test_sequencer;
  import gate_test_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, abort0 = 1'b0, nand_sel = 1'b0;
  logic       start1 = 1'b0, abort1 = 1'b0;
  logic       a0, b0, y0, busy0, done0, pass0;
  logic [3:0] result0, mask0;
  logic       a1, b1, y1, busy1, done1, pass1;
  logic [3:0] result1, mask1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Gate under test for instance 0: AND or NAND; instance 1: output stuck at 0.
  assign y0 = nand_sel ? ~(a0 & b0) : (a0 & b0);
  assign y1 = 1'b0;

  gate_test_sequencer #(.SETTLE_CYCLES(2), .EXPECTED(TT_AND)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .gate_a(a0), .gate_b(b0), .gate_y(y0), .busy(busy0), .done(done0),
    .result(result0), .pass(pass0), .fail_mask(mask0)
  );

  gate_test_sequencer #(.SETTLE_CYCLES(1), .EXPECTED(TT_AND)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .gate_a(a1), .gate_b(b1), .gate_y(y1), .busy(busy1), .done(done1),
    .result(result1), .pass(pass1), .fail_mask(mask1)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a0, b0, busy0, done0, pass0} !== 5'b0 || result0 !== 4'b0 || mask0 !== 4'b0) begin
      errors++;
      $display("FAIL reset_dut0: got ab=%b%b busy=%b done=%b pass=%b result=%b mask=%b, expected all 0",
               a0, b0, busy0, done0, pass0, result0, mask0);
    end
    checks++;
    if ({a1, b1, busy1, done1, pass1} !== 5'b0 || result1 !== 4'b0 || mask1 !== 4'b0) begin
      errors++;
      $display("FAIL reset_dut1: got ab=%b%b busy=%b done=%b pass=%b result=%b mask=%b, expected all 0",
               a1, b1, busy1, done1, pass1, result1, mask1);
    end
    rst_n = 1'b1;
  endtask

  // AND gate, SETTLE_CYCLES=2: vector k held in cycles 3k+1..3k+3, done at 13.
  task automatic test_and;
    int         done_cyc = 0;
    int         done_cnt = 0;
    logic [1:0] exp_ab;
    logic       exp_busy;
    nand_sel = 1'b0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (done0 === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (c <= 12) begin
        exp_busy = 1'b1;
        exp_ab   = 2'((c - 1) / 3);
      end else begin
        exp_busy = 1'b0;
        exp_ab   = 2'b00;
      end
      checks++;
      if ({a0, b0} !== exp_ab || busy0 !== exp_busy) begin
        errors++;
        $display("FAIL and_drive cycle %0d: got ab=%b%b busy=%b, expected ab=%b busy=%b",
                 c, a0, b0, busy0, exp_ab, exp_busy);
      end
    end
    checks++;
    if (done_cyc != 13 || done_cnt != 1) begin
      errors++;
      $display("FAIL and_done_timing: got first done at cycle %0d count %0d, expected cycle 13 count 1",
               done_cyc, done_cnt);
    end
    checks++;
    if (result0 !== 4'b1000 || pass0 !== 1'b1 || mask0 !== 4'b0000) begin
      errors++;
      $display("FAIL and_verdict: got result=%b pass=%b mask=%b, expected result=1000 pass=1 mask=0000",
               result0, pass0, mask0);
    end
  endtask

  // NAND gate, abort (with start also high) during cycle 5, a SETTLE cycle of vector 1.
  task automatic test_abort;
    int done_cnt = 0;
    nand_sel = 1'b1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 4) begin
        checks++;
        if (result0 !== 4'b0001) begin
          errors++;
          $display("FAIL abort_partial_result: got %b, expected 0001", result0);
        end
      end
    end
    checks++;
    if ({a0, b0} !== 2'b01 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre_state: got ab=%b%b busy=%b, expected ab=01 busy=1", a0, b0, busy0);
    end
    abort0 = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    checks++;
    if ({a0, b0, busy0, done0, pass0} !== 5'b0 || result0 !== 4'b0 || mask0 !== 4'b0) begin
      errors++;
      $display("FAIL abort_idle: got ab=%b%b busy=%b done=%b pass=%b result=%b mask=%b, expected all 0",
               a0, b0, busy0, done0, pass0, result0, mask0);
    end
    abort0 = 1'b0;
    start0 = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done0 === 1'b1 || busy0 === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d cycles with done/busy after abort, expected 0", done_cnt);
    end
  endtask

  // NAND gate, async reset at cycle 7, then a full run from the first edge after release.
  task automatic test_reset_midrun;
    int         done_cyc = 0;
    int         done_cnt = 0;
    logic [1:0] exp_ab;
    logic       exp_busy;
    nand_sel = 1'b1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (result0 !== 4'b0011 || {a0, b0} !== 2'b10 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pre_reset: got result=%b ab=%b%b busy=%b, expected result=0011 ab=10 busy=1",
               result0, a0, b0, busy0);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({a0, b0, busy0, done0, pass0} !== 5'b0 || result0 !== 4'b0 || mask0 !== 4'b0) begin
      errors++;
      $display("FAIL midrun_async_reset: got ab=%b%b busy=%b done=%b pass=%b result=%b mask=%b, expected all 0",
               a0, b0, busy0, done0, pass0, result0, mask0);
    end
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done0 === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      exp_busy = (c <= 12);
      exp_ab   = (c <= 12) ? 2'((c - 1) / 3) : 2'b00;
      checks++;
      if ({a0, b0} !== exp_ab || busy0 !== exp_busy) begin
        errors++;
        $display("FAIL nand_drive cycle %0d: got ab=%b%b busy=%b, expected ab=%b busy=%b",
                 c, a0, b0, busy0, exp_ab, exp_busy);
      end
    end
    checks++;
    if (done_cyc != 13 || done_cnt != 1) begin
      errors++;
      $display("FAIL nand_done_timing: got first done at cycle %0d count %0d, expected cycle 13 count 1",
               done_cyc, done_cnt);
    end
    checks++;
    if (result0 !== 4'b0111 || pass0 !== 1'b0 || mask0 !== 4'b1111) begin
      errors++;
      $display("FAIL nand_verdict: got result=%b pass=%b mask=%b, expected result=0111 pass=0 mask=1111",
               result0, pass0, mask0);
    end
  endtask

  // Stuck-at-0 gate, SETTLE_CYCLES=1, start held high: one done at cycle 9, restart only from IDLE.
  task automatic test_back_to_back;
    int         done_cyc = 0;
    int         done_cnt = 0;
    logic [1:0] exp_ab;
    logic       exp_busy;
    @(negedge clk);
    start1 = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (done1 === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      exp_busy = (c <= 8) || (c == 11);
      exp_ab   = (c <= 8) ? 2'((c - 1) / 2) : 2'b00;
      checks++;
      if ({a1, b1} !== exp_ab || busy1 !== exp_busy) begin
        errors++;
        $display("FAIL stuck_drive cycle %0d: got ab=%b%b busy=%b, expected ab=%b busy=%b",
                 c, a1, b1, busy1, exp_ab, exp_busy);
      end
      if (c == 9) begin
        checks++;
        if (result1 !== 4'b0000 || pass1 !== 1'b0 || mask1 !== 4'b1000) begin
          errors++;
          $display("FAIL stuck_verdict: got result=%b pass=%b mask=%b, expected result=0000 pass=0 mask=1000",
                   result1, pass1, mask1);
        end
      end
    end
    checks++;
    if (done_cyc != 9 || done_cnt != 1) begin
      errors++;
      $display("FAIL stuck_done_timing: got first done at cycle %0d count %0d, expected cycle 9 count 1",
               done_cyc, done_cnt);
    end
    start1 = 1'b0;
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || {a1, b1} !== 2'b00) begin
      errors++;
      $display("FAIL stuck_abort_cleanup: got busy=%b done=%b ab=%b%b, expected all 0",
               busy1, done1, a1, b1);
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
